// File: rtl/openframe_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// openframe_gpio_ctrl : Wishbone-programmable pad controller for the openframe
// pad ring (per-pad modes, safe-hold after reset, synchronisers, edge irqs).
// Revision: 1.0
// ============================================================================
module openframe_gpio_ctrl #(
    parameter int NUM_PADS    = 44,
    parameter int SYNC_STAGES = 2,
    parameter int SAFE_CYCLES = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_PADS-1:0] core_out,
    input  logic [NUM_PADS-1:0] core_oe,
    output logic [NUM_PADS-1:0] core_in,
    input  logic [NUM_PADS-1:0] gpio_in,
    output logic [NUM_PADS-1:0] gpio_out,
    output logic [NUM_PADS-1:0] gpio_oeb,
    output logic [NUM_PADS-1:0] gpio_inp_dis,
    output logic [NUM_PADS-1:0] gpio_dm2,
    output logic [NUM_PADS-1:0] gpio_dm1,
    output logic [NUM_PADS-1:0] gpio_dm0,
    output logic                irq_o
);

    localparam logic [7:0] SAFE_LAST = 8'(SAFE_CYCLES - 1);

    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic                en_q, en_d;
    logic                safe_q, safe_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                irq_q, irq_d;
    logic [NUM_PADS-1:0] out_q, out_d;
    logic [NUM_PADS-1:0] pend_q, pend_d;
    logic [NUM_PADS-1:0] prev_q, prev_d;
    logic [3:0]          mode_q [NUM_PADS];
    logic [3:0]          mode_d [NUM_PADS];
    logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PADS-1:0] sync_d [SYNC_STAGES];

    logic [NUM_PADS-1:0] pout_q, pout_d;
    logic [NUM_PADS-1:0] poeb_q, poeb_d;
    logic [NUM_PADS-1:0] pind_q, pind_d;
    logic [NUM_PADS-1:0] pdm2_q, pdm2_d;
    logic [NUM_PADS-1:0] pdm1_q, pdm1_d;
    logic [NUM_PADS-1:0] pdm0_q, pdm0_d;

    logic                req;
    logic                wr;
    logic [7:0]          widx;
    logic                pads_safe;
    logic [NUM_PADS-1:0] in_sync;
    logic [NUM_PADS-1:0] hit;
    logic [63:0]         in64, out64, pend64, out_new64, clr64;
    logic [31:0]         rdata;
    logic                unused_ok;

    assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr        = req & wbs_we_i;
    assign widx      = wbs_adr_i[9:2];
    assign pads_safe = safe_q | ~en_q;
    assign in_sync   = sync_q[SYNC_STAGES-1];
    assign in64      = 64'(in_sync);
    assign out64     = 64'(out_q);
    assign pend64    = 64'(pend_q);
    assign unused_ok = ^{wbs_adr_i[31:10], wbs_adr_i[1:0], out_new64, clr64};

    // Register read mux; pads beyond NUM_PADS fall out as zero via extension
    always_comb begin
        rdata = 32'd0;
        case (widx)
            8'd0: rdata[0] = en_q;
            8'd1: rdata[0] = safe_q;
            8'd2: rdata = in64[31:0];
            8'd3: rdata = in64[63:32];
            8'd4: rdata = out64[31:0];
            8'd5: rdata = out64[63:32];
            8'd6: rdata = pend64[31:0];
            8'd7: rdata = pend64[63:32];
            default: begin
                for (int k = 0; k < NUM_PADS; k++) begin
                    if (widx == 8'(16 + k)) rdata[3:0] = mode_q[k];
                end
            end
        endcase
    end

    always_comb begin
        ack_d = req;
        dat_d = req ? rdata : 32'd0;

        en_d = en_q;
        if (wr && widx == 8'd0) en_d = wbs_dat_i[0];

        safe_d = safe_q && (cnt_q != SAFE_LAST);
        cnt_d  = safe_q ? cnt_q + 8'd1 : cnt_q;

        out_new64 = out64;
        if (wr && widx == 8'd4) out_new64[31:0]  = wbs_dat_i;
        if (wr && widx == 8'd5) out_new64[63:32] = wbs_dat_i;
        out_d = out_new64[NUM_PADS-1:0];

        clr64 = 64'd0;
        if (wr && widx == 8'd6) clr64[31:0]  = wbs_dat_i;
        if (wr && widx == 8'd7) clr64[63:32] = wbs_dat_i;

        sync_d[0] = gpio_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        prev_d = in_sync;

        for (int k = 0; k < NUM_PADS; k++) begin
            mode_d[k] = mode_q[k];
            if (wr && widx == 8'(16 + k)) mode_d[k] = wbs_dat_i[3:0];
            hit[k] = !pads_safe && (mode_q[k][1:0] != 2'd0) && mode_q[k][2] &&
                     (mode_q[k][3] ? (prev_q[k] & ~in_sync[k])
                                   : (in_sync[k] & ~prev_q[k]));
        end

        // A fresh edge outranks a same-cycle clear so no event is lost
        pend_d = (pend_q & ~clr64[NUM_PADS-1:0]) | hit;
        irq_d  = |pend_q;

        for (int k = 0; k < NUM_PADS; k++) begin
            pout_d[k] = 1'b0;
            poeb_d[k] = 1'b1;
            pind_d[k] = 1'b1;
            pdm2_d[k] = 1'b0;
            pdm1_d[k] = 1'b0;
            pdm0_d[k] = 1'b0;
            if (!pads_safe) begin
                case (mode_q[k][1:0])
                    2'd1: begin
                        pind_d[k] = 1'b0;
                        pdm0_d[k] = 1'b1;
                    end
                    2'd2: begin
                        poeb_d[k] = ~core_oe[k];
                        pout_d[k] = core_out[k];
                        pind_d[k] = 1'b0;
                        pdm2_d[k] = 1'b1;
                        pdm1_d[k] = 1'b1;
                    end
                    2'd3: begin
                        poeb_d[k] = 1'b0;
                        pout_d[k] = out_q[k];
                        pind_d[k] = 1'b0;
                        pdm2_d[k] = 1'b1;
                        pdm1_d[k] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            dat_q  <= 32'd0;
            en_q   <= 1'b0;
            safe_q <= 1'b1;
            cnt_q  <= 8'd0;
            irq_q  <= 1'b0;
            out_q  <= '0;
            pend_q <= '0;
            prev_q <= '0;
            for (int k = 0; k < NUM_PADS; k++) mode_q[k] <= 4'd0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            pout_q <= '0;
            poeb_q <= '1;
            pind_q <= '1;
            pdm2_q <= '0;
            pdm1_q <= '0;
            pdm0_q <= '0;
        end else begin
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            en_q   <= en_d;
            safe_q <= safe_d;
            cnt_q  <= cnt_d;
            irq_q  <= irq_d;
            out_q  <= out_d;
            pend_q <= pend_d;
            prev_q <= prev_d;
            for (int k = 0; k < NUM_PADS; k++) mode_q[k] <= mode_d[k];
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            pout_q <= pout_d;
            poeb_q <= poeb_d;
            pind_q <= pind_d;
            pdm2_q <= pdm2_d;
            pdm1_q <= pdm1_d;
            pdm0_q <= pdm0_d;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign irq_o        = irq_q;
    assign core_in      = in_sync;
    assign gpio_out     = pout_q;
    assign gpio_oeb     = poeb_q;
    assign gpio_inp_dis = pind_q;
    assign gpio_dm2     = pdm2_q;
    assign gpio_dm1     = pdm1_q;
    assign gpio_dm0     = pdm0_q;

endmodule
`default_nettype wire

// File: tb/tb_openframe_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// tb_openframe_gpio_ctrl : directed self-checking bench for openframe_gpio_ctrl.
// Revision: 1.0
// ============================================================================
module tb_openframe_gpio_ctrl;

    localparam int NP   = 44;
    localparam int SAFE = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0]   adr = 32'd0, wdat = 32'd0;
    logic          ack;
    logic [31:0]   rdat;
    logic [NP-1:0] core_out = '0, core_oe = '0, gpio_in = '0;
    logic [NP-1:0] core_in, g_out, g_oeb, g_ind, g_dm2, g_dm1, g_dm0;
    logic          irq;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc_cnt <= 0;
        else     cyc_cnt <= cyc_cnt + 1;
    end

    openframe_gpio_ctrl #(.NUM_PADS(NP), .SYNC_STAGES(2), .SAFE_CYCLES(SAFE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .core_out(core_out), .core_oe(core_oe), .core_in(core_in),
        .gpio_in(gpio_in),
        .gpio_out(g_out), .gpio_oeb(g_oeb), .gpio_inp_dis(g_ind),
        .gpio_dm2(g_dm2), .gpio_dm1(g_dm1), .gpio_dm0(g_dm0),
        .irq_o(irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic w, input int word, input logic [31:0] d,
                           output logic [31:0] q);
        int n = 0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = 32'(word * 4); wdat = d;
        do begin
            tick();
            n++;
        end while (!ack && n < 8);
        q = rdat;
        if (!ack) begin
            n_assert++; n_fail++;
            $display("FAIL wb_timeout word=%0d: ack=%b required 1", word, ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input int word, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, word, d, q);
    endtask

    task automatic wb_read(input int word, output logic [31:0] q);
        wb_xfer(1'b0, word, 32'd0, q);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_assert++;
        if ({g_oeb, g_ind} !== {2*NP{1'b1}} || {g_out, g_dm2, g_dm1, g_dm0} !== '0) begin
            n_fail++;
            $display("FAIL reset_pads: oeb=%h inp_dis=%h out=%h dm2=%h dm1=%h dm0=%h required oeb/inp_dis all 1, rest 0",
                     g_oeb, g_ind, g_out, g_dm2, g_dm1, g_dm0);
        end
        n_assert++;
        if ({ack, rdat, irq, core_in} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b dat=%h irq=%b core_in=%h required all 0",
                     ack, rdat, irq, core_in);
        end
    endtask

    task automatic test_safe_release();
        logic [5:0] obs, exp;
        logic [31:0] q;
        rst = 1'b0;
        wb_write(0, 32'd1);
        wb_write(16, 32'd3);
        wb_write(4, 32'd1);
        while (cyc_cnt < SAFE + 3) begin
            tick();
            obs = {g_out[0], g_oeb[0], g_ind[0], g_dm2[0], g_dm1[0], g_dm0[0]};
            exp = (cyc_cnt <= SAFE) ? 6'b011000 : 6'b100110;
            n_assert++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL safe_release cycle %0d: pad0 {out,oeb,inp_dis,dm}=%b required %b",
                         cyc_cnt, obs, exp);
            end
        end
        wb_read(1, q);
        n_assert++;
        if (q !== 32'd0) begin
            n_fail++;
            $display("FAIL status_after_release: got %h required 0", q);
        end
    endtask

    task automatic test_core_mode();
        core_out[5] = 1'b1;
        core_oe[5]  = 1'b0;
        wb_write(21, 32'd2);
        tick();
        n_assert++;
        if ({g_oeb[5], g_ind[5], g_dm2[5], g_dm1[5], g_dm0[5]} !== 5'b10110) begin
            n_fail++;
            $display("FAIL core_mode_oe0: pad5 oeb=%b inp_dis=%b dm=%b%b%b required oeb=1 inp_dis=0 dm=110",
                     g_oeb[5], g_ind[5], g_dm2[5], g_dm1[5], g_dm0[5]);
        end
        core_oe[5] = 1'b1;
        n_assert++;
        if (g_oeb[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL core_mode_latency: pad5 oeb=%b required 1 before edge", g_oeb[5]);
        end
        tick();
        n_assert++;
        if ({g_oeb[5], g_out[5]} !== 2'b01) begin
            n_fail++;
            $display("FAIL core_mode_oe1: pad5 oeb=%b out=%b required oeb=0 out=1", g_oeb[5], g_out[5]);
        end
        wb_write(21, 32'd0);
        tick();
        n_assert++;
        if ({g_out[5], g_oeb[5], g_ind[5], g_dm2[5], g_dm1[5], g_dm0[5]} !== 6'b011000) begin
            n_fail++;
            $display("FAIL core_mode_disable: pad5 {out,oeb,inp_dis,dm}=%b required 011000",
                     {g_out[5], g_oeb[5], g_ind[5], g_dm2[5], g_dm1[5], g_dm0[5]});
        end
    endtask

    task automatic test_input_irq();
        logic [31:0] q;
        wb_write(19, 32'h5);
        tick();
        n_assert++;
        if ({g_oeb[3], g_ind[3], g_dm2[3], g_dm1[3], g_dm0[3]} !== 5'b10001) begin
            n_fail++;
            $display("FAIL input_mode_pad: pad3 oeb=%b inp_dis=%b dm=%b%b%b required oeb=1 inp_dis=0 dm=001",
                     g_oeb[3], g_ind[3], g_dm2[3], g_dm1[3], g_dm0[3]);
        end
        gpio_in[3] = 1'b1;
        tick();
        n_assert++;
        if (core_in[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_latency_1: core_in[3]=%b required 0", core_in[3]);
        end
        tick();
        n_assert++;
        if (core_in[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_latency_2: core_in[3]=%b required 1", core_in[3]);
        end
        tick();
        n_assert++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_latency_3: irq=%b required 0", irq);
        end
        tick();
        n_assert++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_latency_4: irq=%b required 1", irq);
        end
        wb_read(2, q);
        n_assert++;
        if (q !== 32'h8) begin
            n_fail++;
            $display("FAIL in_lo: got %h required 00000008", q);
        end
        wb_read(6, q);
        n_assert++;
        if (q !== 32'h8) begin
            n_fail++;
            $display("FAIL pend_lo: got %h required 00000008", q);
        end
        wb_write(6, 32'h8);
        tick();
        n_assert++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_w1c: irq=%b required 0", irq);
        end
    endtask

    task automatic test_fall_w1c();
        logic [31:0] q;
        gpio_in[40] = 1'b1;
        repeat (4) tick();
        wb_write(16 + 40, 32'hD);
        repeat (2) tick();
        gpio_in[40] = 1'b0;
        repeat (2) tick();
        // This write commits on the very edge that records the falling edge
        wb_write(7, 32'h100);
        wb_read(7, q);
        n_assert++;
        if (q !== 32'h100) begin
            n_fail++;
            $display("FAIL set_beats_clear: PEND_HI=%h required 00000100", q);
        end
        wb_write(7, 32'h100);
        wb_read(7, q);
        n_assert++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL pend_hi_clear: PEND_HI=%h required 0", q);
        end
        tick();
        n_assert++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_after_hi_clear: irq=%b required 0", irq);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] q;
        wb_write(60, 32'hFFFF_FFFF);
        wb_read(60, q);
        n_assert++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL word60_read: got %h required 0", q);
        end
        wb_read(59, q);
        n_assert++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL mode43_untouched: got %h required 0", q);
        end
        wb_read(0, q);
        n_assert++;
        if (q !== 32'h1) begin
            n_fail++;
            $display("FAIL ctrl_untouched: got %h required 00000001", q);
        end
        wb_read(8, q);
        n_assert++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL word8_read: got %h required 0", q);
        end
        wb_write(17, 32'hFFFF_FFFF);
        wb_read(17, q);
        n_assert++;
        if (q !== 32'hF) begin
            n_fail++;
            $display("FAIL mode_upper_bits: got %h required 0000000f", q);
        end
        wb_write(17, 32'h0);
        wb_write(5, 32'hFFFF_FFFF);
        wb_read(5, q);
        n_assert++;
        if (q !== 32'h0000_0FFF) begin
            n_fail++;
            $display("FAIL out_hi_width: got %h required 00000fff", q);
        end
        wb_write(5, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_ack = (i % 2 == 0);
            n_assert++;
            if (ack !== exp_ack || rdat !== (exp_ack ? 32'd1 : 32'd0)) begin
                n_fail++;
                $display("FAIL back_to_back beat %0d: ack=%b dat=%h required ack=%b dat=%h",
                         i, ack, rdat, exp_ack, exp_ack ? 32'd1 : 32'd0);
            end
        end
        cyc = 1'b0; stb = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        logic [31:0] q;
        gpio_in[3] = 1'b0;
        repeat (3) tick();
        gpio_in[3] = 1'b1;
        repeat (5) tick();
        n_assert++;
        if (irq !== 1'b1 || g_oeb[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_state: irq=%b pad0 oeb=%b required irq=1 oeb=0", irq, g_oeb[0]);
        end
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd4;
        tick();
        #2 rst = 1'b1;
        #1;
        n_assert++;
        if ({g_oeb, g_ind} !== {2*NP{1'b1}} || {g_out, g_dm2, g_dm1, g_dm0} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_pads: oeb=%h inp_dis=%h out=%h dm2=%h dm1=%h dm0=%h required safe encoding",
                     g_oeb, g_ind, g_out, g_dm2, g_dm1, g_dm0);
        end
        n_assert++;
        if ({ack, irq, rdat} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_bus: ack=%b irq=%b dat=%h required all 0", ack, irq, rdat);
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        wb_read(1, q);
        n_assert++;
        if (q !== 32'h1) begin
            n_fail++;
            $display("FAIL safe_after_reset: STATUS=%h required 00000001", q);
        end
        wb_read(16, q);
        n_assert++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL mode0_after_reset: got %h required 0", q);
        end
    endtask

    initial begin
        test_reset();
        test_safe_release();
        test_core_mode();
        test_input_irq();
        test_fall_w1c();
        test_unmapped();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
